// File: rtl/ethernet_header_inserter_deadlock_detector.sv
// Confirms a deadlock when the per-process block monitors stay asserted, without progress,
// for CONFIRM_CYCLES cycles. Optional cycle counter: DEADLOCK_DETECTOR_CYCLE_COUNT_EN.
module ethernet_header_inserter_deadlock_detector #(
    parameter int NUM_MON        = 4,
    parameter int IDX_W          = 2,
    parameter int CONFIRM_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_MON-1:0] block_sigs,
    input  logic               clear,
    output logic               suspect,
    output logic               deadlock,
    output logic [IDX_W-1:0]   deadlock_idx,
    output logic [NUM_MON-1:0] deadlock_mask
`ifdef DEADLOCK_DETECTOR_CYCLE_COUNT_EN
    ,
    output logic [31:0]        deadlock_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SUSPECT   = 2'd1,
        CONFIRMED = 2'd2
    } state_t;

    localparam logic             DIRECT_CONFIRM = (CONFIRM_CYCLES == 1);
    localparam logic [CNT_W-1:0] CNT_TARGET     = CNT_W'(CONFIRM_CYCLES);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_MON-1:0]   snap_q, snap_d;
    logic                 suspect_q;
    logic                 deadlock_q, deadlock_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [NUM_MON-1:0]   mask_q, mask_d;
    logic                 any_s;
    logic [NUM_MON-1:0]   lost_s;
    logic [NUM_MON-1:0]   merged_s;
    logic [CNT_W-1:0]     cnt_inc_s;

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_MON-1:0] v);
        logic [IDX_W-1:0] r;
        r = {IDX_W{1'b0}};
        for (int i = NUM_MON - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = IDX_W'(i);
            end
        end
        return r;
    endfunction

    assign any_s     = |block_sigs;
    assign lost_s    = snap_q & ~block_sigs;
    assign merged_s  = snap_q | block_sigs;
    assign cnt_inc_s = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    // Next-state logic; the count is never stored at the target, so it cannot wrap.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        snap_d     = snap_q;
        deadlock_d = deadlock_q;
        idx_d      = idx_q;
        mask_d     = mask_q;
        case (state_q)
            IDLE: begin
                if (any_s) begin
                    if (DIRECT_CONFIRM) begin
                        state_d    = CONFIRMED;
                        deadlock_d = 1'b1;
                        mask_d     = block_sigs;
                        idx_d      = lowest_idx(block_sigs);
                        cnt_d      = {CNT_W{1'b0}};
                        snap_d     = {NUM_MON{1'b0}};
                    end else begin
                        state_d = SUSPECT;
                        snap_d  = block_sigs;
                        cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SUSPECT: begin
                if (!any_s) begin
                    state_d = IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                    snap_d  = {NUM_MON{1'b0}};
                end else if (lost_s != {NUM_MON{1'b0}}) begin
                    snap_d = block_sigs;
                    cnt_d  = {{(CNT_W-1){1'b0}}, 1'b1};
                end else if (cnt_inc_s == CNT_TARGET) begin
                    state_d    = CONFIRMED;
                    deadlock_d = 1'b1;
                    mask_d     = merged_s;
                    idx_d      = lowest_idx(merged_s);
                    cnt_d      = {CNT_W{1'b0}};
                    snap_d     = {NUM_MON{1'b0}};
                end else begin
                    snap_d = merged_s;
                    cnt_d  = cnt_inc_s;
                end
            end
            CONFIRMED: begin
                if (clear) begin
                    state_d    = IDLE;
                    deadlock_d = 1'b0;
                    idx_d      = {IDX_W{1'b0}};
                    mask_d     = {NUM_MON{1'b0}};
                    cnt_d      = {CNT_W{1'b0}};
                    snap_d     = {NUM_MON{1'b0}};
                end else begin
                    state_d = CONFIRMED;
                end
            end
            default: begin
                state_d    = IDLE;
                cnt_d      = {CNT_W{1'b0}};
                snap_d     = {NUM_MON{1'b0}};
                deadlock_d = 1'b0;
                idx_d      = {IDX_W{1'b0}};
                mask_d     = {NUM_MON{1'b0}};
            end
        endcase
    end

    // State and registered-output update; reset overrides everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            snap_q     <= {NUM_MON{1'b0}};
            suspect_q  <= 1'b0;
            deadlock_q <= 1'b0;
            idx_q      <= {IDX_W{1'b0}};
            mask_q     <= {NUM_MON{1'b0}};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            snap_q     <= snap_d;
            suspect_q  <= (state_d == SUSPECT);
            deadlock_q <= deadlock_d;
            idx_q      <= idx_d;
            mask_q     <= mask_d;
        end
    end

    assign suspect       = suspect_q;
    assign deadlock      = deadlock_q;
    assign deadlock_idx  = idx_q;
    assign deadlock_mask = mask_q;

`ifdef DEADLOCK_DETECTOR_CYCLE_COUNT_EN
    logic [31:0] cycles_q, cycles_d;

    // Cycles spent in CONFIRMED: 1 on entry, saturating at all-ones.
    always_comb begin
        cycles_d = cycles_q;
        if (state_d == CONFIRMED) begin
            if (state_q != CONFIRMED) begin
                cycles_d = 32'd1;
            end else if (cycles_q != 32'hFFFF_FFFF) begin
                cycles_d = cycles_q + 32'd1;
            end else begin
                cycles_d = cycles_q;
            end
        end else begin
            cycles_d = 32'd0;
        end
    end

    // Cycle counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            cycles_q <= 32'd0;
        end else begin
            cycles_q <= cycles_d;
        end
    end

    assign deadlock_cycles = cycles_q;
`endif

endmodule

// File: tb/tb_ethernet_header_inserter_deadlock_detector.sv
// Directed bench with CONFIRM_CYCLES=4; observed word is {suspect, deadlock, idx[1:0], mask[3:0]}.
module tb_ethernet_header_inserter_deadlock_detector;

    logic       clock;
    logic       reset;
    logic [3:0] block_sigs;
    logic       clear;
    logic       suspect;
    logic       deadlock;
    logic [1:0] deadlock_idx;
    logic [3:0] deadlock_mask;
`ifdef DEADLOCK_DETECTOR_CYCLE_COUNT_EN
    logic [31:0] deadlock_cycles;
`endif
    logic [7:0] obs;
    int         n_cmp;
    int         n_bad;

    ethernet_header_inserter_deadlock_detector #(
        .NUM_MON(4), .IDX_W(2), .CONFIRM_CYCLES(4), .CNT_W(3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .block_sigs(block_sigs),
        .clear(clear),
        .suspect(suspect),
        .deadlock(deadlock),
        .deadlock_idx(deadlock_idx),
        .deadlock_mask(deadlock_mask)
`ifdef DEADLOCK_DETECTOR_CYCLE_COUNT_EN
        ,
        .deadlock_cycles(deadlock_cycles)
`endif
    );

    assign obs = {suspect, deadlock, deadlock_idx, deadlock_mask};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drop_to_idle();
        block_sigs = 4'b0000;
        clear = 1'b1;
        step();
        clear = 1'b0;
        step();
        n_cmp++;
        if (obs !== 8'h00) begin
            n_bad++;
            $display("FAIL idle_after_clear got %b want %b", obs, 8'h00);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        block_sigs = 4'b1111;
        clear = 1'b0;
        step();
        step();
        n_cmp++;
        if (obs !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_state got %b want %b", obs, 8'h00);
        end
        reset = 1'b0;
        block_sigs = 4'b0000;
        step();
    endtask

    task automatic test_basic_confirm();
        block_sigs = 4'b0010;
        for (int i = 1; i <= 3; i++) begin
            step();
            n_cmp++;
            if (obs !== 8'b1000_0000) begin
                n_bad++;
                $display("FAIL basic_edge%0d got %b want %b", i, obs, 8'b1000_0000);
            end
        end
        step();
        n_cmp++;
        if (obs !== 8'b0101_0010) begin
            n_bad++;
            $display("FAIL basic_confirm got %b want %b", obs, 8'b0101_0010);
        end
        // outputs must hold in CONFIRMED even as block_sigs changes
        block_sigs = 4'b1000;
        step();
        step();
        n_cmp++;
        if (obs !== 8'b0101_0010) begin
            n_bad++;
            $display("FAIL confirmed_hold got %b want %b", obs, 8'b0101_0010);
        end
        drop_to_idle();
    endtask

    task automatic test_gap_restart();
        block_sigs = 4'b0010;
        for (int i = 0; i < 3; i++) step();
        block_sigs = 4'b0000;
        step();
        n_cmp++;
        if (obs !== 8'h00) begin
            n_bad++;
            $display("FAIL gap_idle got %b want %b", obs, 8'h00);
        end
        block_sigs = 4'b0010;
        for (int i = 1; i <= 3; i++) begin
            step();
            n_cmp++;
            if (obs !== 8'b1000_0000) begin
                n_bad++;
                $display("FAIL gap_edge%0d got %b want %b", i, obs, 8'b1000_0000);
            end
        end
        step();
        n_cmp++;
        if (obs !== 8'b0101_0010) begin
            n_bad++;
            $display("FAIL gap_confirm got %b want %b", obs, 8'b0101_0010);
        end
        drop_to_idle();
    endtask

    task automatic test_join();
        block_sigs = 4'b0010;
        step();
        step();
        block_sigs = 4'b0110;
        step();
        n_cmp++;
        if (obs !== 8'b1000_0000) begin
            n_bad++;
            $display("FAIL join_edge3 got %b want %b", obs, 8'b1000_0000);
        end
        step();
        n_cmp++;
        if (obs !== 8'b0101_0110) begin
            n_bad++;
            $display("FAIL join_confirm got %b want %b", obs, 8'b0101_0110);
        end
        drop_to_idle();
    endtask

    task automatic test_progress_restart();
        block_sigs = 4'b0110;
        step();
        step();
        block_sigs = 4'b0100;
        for (int i = 1; i <= 3; i++) begin
            step();
            n_cmp++;
            if (obs !== 8'b1000_0000) begin
                n_bad++;
                $display("FAIL restart_edge%0d got %b want %b", i, obs, 8'b1000_0000);
            end
        end
        step();
        n_cmp++;
        if (obs !== 8'b0110_0100) begin
            n_bad++;
            $display("FAIL restart_confirm got %b want %b", obs, 8'b0110_0100);
        end
        // clear while still blocked: IDLE on this edge, SUSPECT on the next
        block_sigs = 4'b1000;
        clear = 1'b1;
        step();
        clear = 1'b0;
        n_cmp++;
        if (obs !== 8'h00) begin
            n_bad++;
            $display("FAIL clear_blocked got %b want %b", obs, 8'h00);
        end
        step();
        n_cmp++;
        if (obs !== 8'b1000_0000) begin
            n_bad++;
            $display("FAIL rearm_suspect got %b want %b", obs, 8'b1000_0000);
        end
        block_sigs = 4'b0000;
        step();
    endtask

    task automatic test_clear_in_suspect();
        block_sigs = 4'b0001;
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        step();
        step();
        n_cmp++;
        if (obs !== 8'b0100_0001) begin
            n_bad++;
            $display("FAIL clear_suspect got %b want %b", obs, 8'b0100_0001);
        end
        drop_to_idle();
    endtask

    task automatic test_reset_mid();
        block_sigs = 4'b0010;
        for (int i = 0; i < 3; i++) step();
        reset = 1'b1;
        step();
        n_cmp++;
        if (obs !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_suspect got %b want %b", obs, 8'h00);
        end
        reset = 1'b0;
        block_sigs = 4'b0000;
        step();
        step();
        n_cmp++;
        if (obs !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_no_confirm got %b want %b", obs, 8'h00);
        end
        block_sigs = 4'b1000;
        for (int i = 0; i < 4; i++) step();
        reset = 1'b1;
        clear = 1'b1;
        step();
        reset = 1'b0;
        clear = 1'b0;
        block_sigs = 4'b0000;
        n_cmp++;
        if (obs !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_confirmed got %b want %b", obs, 8'h00);
        end
        step();
    endtask

`ifdef DEADLOCK_DETECTOR_CYCLE_COUNT_EN
    task automatic test_cycle_count();
        block_sigs = 4'b0100;
        for (int i = 0; i < 4; i++) step();
        n_cmp++;
        if (deadlock_cycles !== 32'd1) begin
            n_bad++;
            $display("FAIL cycles_entry got %0d want %0d", deadlock_cycles, 1);
        end
        for (int i = 0; i < 9; i++) step();
        n_cmp++;
        if (deadlock_cycles !== 32'd10) begin
            n_bad++;
            $display("FAIL cycles_ten got %0d want %0d", deadlock_cycles, 10);
        end
        block_sigs = 4'b0000;
        clear = 1'b1;
        step();
        clear = 1'b0;
        n_cmp++;
        if (deadlock_cycles !== 32'd0) begin
            n_bad++;
            $display("FAIL cycles_clear got %0d want %0d", deadlock_cycles, 0);
        end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        block_sigs = 4'b0000;
        clear = 1'b0;
        test_reset();
        test_basic_confirm();
        test_gap_restart();
        test_join();
        test_progress_restart();
        test_clear_in_suspect();
        test_reset_mid();
`ifdef DEADLOCK_DETECTOR_CYCLE_COUNT_EN
        test_cycle_count();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
